// File: rtl/exu_latency_ctrl_pkg.sv
// Shared constants for the execution-latency controller: state encodings,
// error codes and the default latency-count width.
package exu_latency_ctrl_pkg;

  localparam int LC_MAX_DELAY_WIDTH = 4;

  // 2'b00 is not a legal state. A controller found there returns to IDLE.
  typedef enum logic [1:0] {
    LC_IDLE = 2'b11,
    LC_BUSY = 2'b01,
    LC_VAR  = 2'b10
  } lc_state_e;

  localparam logic [1:0] LC_ERR_NONE    = 2'b00;
  localparam logic [1:0] LC_ERR_ZERO    = 2'b01;
  localparam logic [1:0] LC_ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] LC_ERR_SPUR    = 2'b11;

endpackage

// File: rtl/exu_latency_ctrl_perf_cnt.sv
// Free-running performance counter. It wraps modulo 2^W, and a clear takes
// priority over an increment.
module exu_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up when enabled. A clear always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/exu_latency_ctrl.sv
// Execution-latency controller. It decides when the current instruction has
// completed and grants exu_ready, which enables the PC/IR refresh.
//
// state | meaning
// IDLE  | no instruction in flight; the next valid IR issues at once
// BUSY  | fixed-latency IR; completes when count reaches target
// VAR   | variable-latency IR; completes on unit_done, or times out at count max
module exu_latency_ctrl
  import exu_latency_ctrl_pkg::*;
#(
  parameter int CNT_W  = LC_MAX_DELAY_WIDTH,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  lc_i_pc_cycle,
  input  logic              lc_i_var_lat,
  input  logic              lc_i_ifu_valid,
  input  logic              lc_i_unit_done,
  input  logic              lc_i_stall,
  input  logic              lc_i_flush,
  input  logic              lc_i_err_clr,
  input  logic              lc_i_perf_clr,
  output logic              lc_o_exu_ready,
  output logic [1:0]        lc_o_state,
  output logic [CNT_W-1:0]  lc_o_count,
  output logic              lc_o_delay_err,
  output logic [1:0]        lc_o_err_code,
  output logic [PERF_W-1:0] lc_o_busy_cnt,
  output logic [PERF_W-1:0] lc_o_wait_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_target;
  logic             r_delay_err;
  logic [1:0]       r_err_code;

  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_target_nxt;
  logic             w_done_now;
  logic             w_ready;
  logic             w_legal;
  logic             w_timeout;
  logic             w_err_zero;
  logic             w_err_spur;
  logic [1:0]       w_err_code_new;
  logic             w_busy_inc;
  logic             w_wait_inc;

  // Completion detection and the issue permission.
  always_comb begin
    w_done_now = 1'b0;
    w_legal    = 1'b1;
    case (r_state)
      LC_IDLE: w_done_now = 1'b0;
      LC_BUSY: w_done_now = (r_count == r_target) & ~lc_i_stall;
      LC_VAR:  w_done_now = lc_i_unit_done & ~lc_i_stall;
      default: w_legal    = 1'b0;
    endcase
    w_ready = lc_i_ifu_valid & ~lc_i_stall & ~lc_i_flush &
              ((r_state == LC_IDLE) | w_done_now);
  end

  assign w_timeout = (r_state == LC_VAR) & (r_count == CNT_MAX) &
                     ~lc_i_unit_done & ~lc_i_stall & ~lc_i_flush;

  // Next state, count and target. The order is flush, illegal-state recovery,
  // issue, then stall hold. After those, the state handles its own progress.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_target_nxt = r_target;
    if (lc_i_flush) begin
      w_state_nxt = LC_IDLE;
      w_count_nxt = CNT_ONE;
    end else if (!w_legal) begin
      w_state_nxt = LC_IDLE;
      w_count_nxt = CNT_ONE;
    end else if (w_ready) begin
      w_state_nxt  = lc_i_var_lat ? LC_VAR : LC_BUSY;
      w_count_nxt  = CNT_ONE;
      w_target_nxt = (lc_i_pc_cycle == '0) ? CNT_ONE : lc_i_pc_cycle;
    end else if (!lc_i_stall) begin
      case (r_state)
        LC_BUSY: begin
          if (w_done_now) w_state_nxt = LC_IDLE;
          else            w_count_nxt = r_count + CNT_ONE;
        end
        LC_VAR: begin
          if (w_done_now) begin
            w_state_nxt = LC_IDLE;
          end else if (r_count == CNT_MAX) begin
            w_state_nxt = LC_IDLE;
            w_count_nxt = CNT_ONE;
          end else begin
            w_count_nxt = r_count + CNT_ONE;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Error classification. A zero-cycle issue and a spurious done can occur
  // in the same cycle; the zero-cycle code is recorded.
  always_comb begin
    w_err_zero     = w_ready & (lc_i_pc_cycle == '0);
    w_err_spur     = lc_i_unit_done & (r_state != LC_VAR);
    w_err_code_new = LC_ERR_NONE;
    if (w_err_zero)      w_err_code_new = LC_ERR_ZERO;
    else if (w_err_spur) w_err_code_new = LC_ERR_SPUR;
    else if (w_timeout)  w_err_code_new = LC_ERR_TIMEOUT;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LC_IDLE;
      r_count  <= CNT_ONE;
      r_target <= CNT_ONE;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Sticky error. It keeps the first error. A clear that arrives with a new
  // error lets the new error be recorded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delay_err <= 1'b0;
      r_err_code  <= LC_ERR_NONE;
    end else if ((w_err_code_new != LC_ERR_NONE) && (!r_delay_err || lc_i_err_clr)) begin
      r_delay_err <= 1'b1;
      r_err_code  <= w_err_code_new;
    end else if (lc_i_err_clr) begin
      r_delay_err <= 1'b0;
      r_err_code  <= LC_ERR_NONE;
    end
  end

  assign w_busy_inc = (r_state == LC_BUSY) | (r_state == LC_VAR);
  assign w_wait_inc = (r_state == LC_IDLE) & ~lc_i_ifu_valid;

  exu_perf_cnt #(.W(PERF_W)) u_busy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_busy_inc),
    .i_clr (lc_i_perf_clr),
    .o_cnt (lc_o_busy_cnt)
  );

  exu_perf_cnt #(.W(PERF_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wait_inc),
    .i_clr (lc_i_perf_clr),
    .o_cnt (lc_o_wait_cnt)
  );

  assign lc_o_exu_ready = w_ready;
  assign lc_o_state     = r_state;
  assign lc_o_count     = r_count;
  assign lc_o_delay_err = r_delay_err;
  assign lc_o_err_code  = r_err_code;

endmodule

// File: doc/exu_latency_ctrl.md
Name: exu_latency_ctrl

Overview:
Next-generation execution-latency controller. It decides when the current instruction has finished and generates exu_ready, the permission for PC/IR refresh. Adds to the previous generation:
- parametrised count width
- variable-latency instructions (completion by unit done strobe)
- stall and flush
- sticky error reporting with codes
- busy/wait performance counters

It sits between the IFU valid path and the EXU, and drives the PC/IR update enable.

Parameters:
CNT_W, 4, width of cycle count and latency target (matches MAX_DELAY_WIDTH)
PERF_W, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; asynchronous, active-low
lc_i_pc_cycle  in  CNT_W  cycle count of next IR; sampled at issue
lc_i_var_lat  in  1  next IR is variable latency; sampled at issue
lc_i_ifu_valid  in  1  next IR valid from IFU
lc_i_unit_done  in  1  variable-latency unit completion strobe
lc_i_stall  in  1  freeze controller this cycle
lc_i_flush  in  1  abort in-flight IR
lc_i_err_clr  in  1  clear sticky error
lc_i_perf_clr  in  1  clear perf counters
lc_o_exu_ready  out  1  issue/refresh permission (combinational)
lc_o_state  out  2  registered state
lc_o_count  out  CNT_W  current count
lc_o_delay_err  out  1  sticky error flag
lc_o_err_code  out  2  code of first error since clear
lc_o_busy_cnt  out  PERF_W  cycles spent in BUSY or VAR
lc_o_wait_cnt  out  PERF_W  cycles in IDLE with ifu_valid=0

Behaviour:
- States (shared constants): IDLE=2'b11, BUSY=2'b01, VAR=2'b10. 2'b00 is illegal and recovers to IDLE next cycle with no issue.
- Reset values:
  - state=IDLE, count=1, target=1
  - delay_err=0, err_code=2'b00
  - both perf counters=0
  - exu_ready is combinational and therefore 0 while ifu_valid=0.
- done_now:
  - BUSY: (count==target) & ~stall
  - VAR: unit_done & ~stall
  - IDLE: 0
- lc_o_exu_ready = ifu_valid & ~stall & ~flush & (state==IDLE | done_now).
- Issue occurs on the edge where exu_ready=1:
  - count<=1
  - target <= (pc_cycle==0 ? 1 : pc_cycle)
  - state <= var_lat ? VAR : BUSY
- Latency: an N-cycle fixed IR occupies exactly N cycles. With pc_cycle=1 and ifu_valid held high, exu_ready=1 every cycle.
- done_now & ~ifu_valid: state<=IDLE, count holds.
- BUSY, not done, ~stall: count<=count+1. count never exceeds target.
- VAR, ~stall, no done: count<=count+1, saturating at 2^CNT_W-1.
  - Timeout when count==2^CNT_W-1 & ~unit_done & ~stall: state<=IDLE, count<=1, error TIMEOUT.
- Stall: all state, count and target hold; exu_ready=0. Perf counters still count.
- Flush: highest priority after reset. state<=IDLE, count<=1, exu_ready=0 that cycle. Flush together with stall means flush wins.
- Errors (sticky):
  - 01 ZERO_CYC: issue with pc_cycle==0.
  - 10 TIMEOUT: see VAR timeout above.
  - 11 SPURIOUS: unit_done=1 while state!=VAR.
  - First error sets delay_err=1 and err_code; later errors do not overwrite.
  - err_clr clears both. err_clr in the same cycle as a new error: the new error is recorded.
- Perf counters: wrap modulo 2^PERF_W. perf_clr zeroes both next edge; perf_clr has priority over increment.
- Reset asserted mid-operation: immediate return to reset values. The in-flight IR is lost without an error.

Decomposition:
- Shared defines file (mcu_defines.v):
  - state encodings LC_IDLE/LC_BUSY/LC_VAR
  - error codes LC_ERR_ZERO/TIMEOUT/SPUR
  - default MAX_DELAY_WIDTH feeding CNT_W
- Sub-module: exu_perf_cnt (PERF_W counter with inc/clr), instantiated twice.

Test Plan:
- Reset, pc_cycle=3, var_lat=0, ifu_valid=1 held -> exu_ready=1 in first post-reset cycle, then on every 3rd cycle; count sequence 1,2,3,1,2,3; busy_cnt=3 per IR.
- pc_cycle=2, ifu_valid drops at completion for 4 cycles -> state=IDLE, exu_ready=0, wait_cnt +4; ifu_valid rises -> exu_ready=1 that same cycle.
- var_lat=1, unit_done pulsed on 5th VAR cycle -> exu_ready=1 in that cycle with ifu_valid=1. Later, unit_done in BUSY -> delay_err=1, err_code=11.
- CNT_W=4, var_lat=1, no unit_done -> timeout at count=15: state IDLE, err_code=10. A subsequent pc_cycle=0 issue keeps code 10 and runs as a 1-cycle IR. After err_clr, a pc_cycle=0 issue gives err_code=01.
- pc_cycle=4 with 2-cycle stall in mid-BUSY -> completion delayed by exactly 2 cycles. Flush at count=2 -> IDLE next cycle, count=1, exu_ready=0 during the flush cycle.
- rst_n low at count=3 of a 5-cycle IR -> state=IDLE, count=1, counters and error cleared asynchronously; normal issue resumes after release.
